// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU op selects, RV32I opcodes, operand-source selects
// and the immediate-format classifier used by the decode stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_PASS_A = 4'b1111;
    localparam logic [3:0] ALU_PASS_B = 4'b1110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_Z
    } imm_fmt_e;

    // Immediate format implied by the opcode; SYSTEM only carries zimm for the
    // register-less CSR forms (funct3 bit 2 set).
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode, input logic f3_b2);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (opcode)
            OP_IMM, OP_JALR, OP_LOAD: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            OP_SYSTEM:                fmt = f3_b2 ? IMM_Z : IMM_NONE;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/alu_dec_imm_gen.sv
// Combinational immediate generator: RV32I instruction word to the
// sign-extended I/S/B/U/J immediate or the zero-extended CSR zimm.
module imm_gen
    import alu_pkg::*;
#(
    parameter int W_SIZE = 32
) (
    input  logic [31:0]       inst_i,
    output logic [W_SIZE-1:0] imm_o
);

    logic signed [31:0] imm32;
    imm_fmt_e           fmt;

    assign fmt = imm_fmt(inst_i[6:0], inst_i[14]);

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U:   imm32 = {inst_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, inst_i[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends to wider datapaths; zimm has bit 31 clear.
    assign imm_o = W_SIZE'(imm32);

endmodule

// File: rtl/alu_dec.sv
// Registered RV32I ALU-control decode stage with valid/ready handshake and flush.
// Optional feature macro: ALU_DEC_ILLEGAL_EN adds the registered `illegal` output.
module alu_dec
    import alu_pkg::*;
#(
    parameter int W_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [W_SIZE-1:0] pc_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_sel,
    output logic              a_sel,
    output logic              b_sel,
    output logic [W_SIZE-1:0] imm,
    output logic [W_SIZE-1:0] pc_out
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic              illegal
`endif
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic              f7b5;
    logic [3:0]        alu_sel_d, alu_sel_q;
    logic              a_sel_d, a_sel_q;
    logic              b_sel_d, b_sel_q;
    logic [W_SIZE-1:0] imm_d, imm_q;
    logic [W_SIZE-1:0] pc_q;
    logic              out_valid_d, out_valid_q;
    logic              load;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7b5   = inst[30];

    imm_gen #(.W_SIZE(W_SIZE)) u_imm_gen (
        .inst_i (inst),
        .imm_o  (imm_d)
    );

    always_comb begin
        alu_sel_d = ALU_ADD;
        a_sel_d   = A_SEL_RS1;
        b_sel_d   = B_SEL_RS2;
        case (opcode)
            // Bit 3 only for SUB/SRA so R-type never aliases the pass codes.
            OP_R: begin
                alu_sel_d = {f7b5 & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
            end
            OP_IMM: begin
                alu_sel_d = {(f3 == 3'b101) & f7b5, f3};
                b_sel_d   = B_SEL_IMM;
            end
            OP_LUI: begin
                alu_sel_d = ALU_PASS_B;
                b_sel_d   = B_SEL_IMM;
            end
            OP_AUIPC, OP_JAL, OP_BRANCH: begin
                a_sel_d = A_SEL_PC;
                b_sel_d = B_SEL_IMM;
            end
            OP_JALR, OP_LOAD, OP_STORE: begin
                b_sel_d = B_SEL_IMM;
            end
            OP_SYSTEM: begin
                if (f3[2]) begin
                    alu_sel_d = ALU_PASS_B;
                    b_sel_d   = B_SEL_IMM;
                end else begin
                    alu_sel_d = ALU_PASS_A;
                end
            end
            default: begin
                alu_sel_d = ALU_ADD;
            end
        endcase
    end

`ifdef ALU_DEC_ILLEGAL_EN
    logic [6:0] f7;
    logic       illegal_d, illegal_q;

    assign f7 = inst[31:25];

    always_comb begin
        illegal_d = (inst[1:0] != 2'b11);
        case (opcode)
            OP_R: begin
                if (f7 == 7'b0100000) begin
                    if ((f3 != 3'b000) && (f3 != 3'b101)) illegal_d = 1'b1;
                end else if (f7 != 7'b0000000) begin
                    illegal_d = 1'b1;
                end
            end
            OP_IMM: begin
                if ((f3 == 3'b001) && (f7 != 7'b0000000)) illegal_d = 1'b1;
                if ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000))
                    illegal_d = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_SYSTEM: begin
            end
            default: illegal_d = 1'b1;
        endcase
    end
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (load)      out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    // Data registers reset as well: outputs must read zero straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_sel_q   <= ALU_ADD;
            a_sel_q     <= 1'b0;
            b_sel_q     <= 1'b0;
            imm_q       <= '0;
            pc_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                alu_sel_q <= alu_sel_d;
                a_sel_q   <= a_sel_d;
                b_sel_q   <= b_sel_d;
                imm_q     <= imm_d;
                pc_q      <= pc_in;
            end
        end
    end

`ifdef ALU_DEC_ILLEGAL_EN
    always_ff @(posedge clk) begin
        if (!rst_n)    illegal_q <= 1'b0;
        else if (load) illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

    assign out_valid = out_valid_q;
    assign alu_sel   = alu_sel_q;
    assign a_sel     = a_sel_q;
    assign b_sel     = b_sel_q;
    assign imm       = imm_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_alu_dec.sv
// Self-checking bench for alu_dec: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural decode/handshake model.
module tb_alu_dec;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, flush, out_ready;
    logic [31:0]  inst;
    logic [W-1:0] pc_in;
    logic         in_ready, out_valid, a_sel, b_sel;
    logic [3:0]   alu_sel;
    logic [W-1:0] imm, pc_out;
`ifdef ALU_DEC_ILLEGAL_EN
    logic         illegal;
`endif

    always #5 clk = ~clk;

    alu_dec #(.W_SIZE(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .pc_in     (pc_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sel   (alu_sel),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .imm       (imm),
        .pc_out    (pc_out)
`ifdef ALU_DEC_ILLEGAL_EN
        ,
        .illegal   (illegal)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  alu;
        logic        a;
        logic        b;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    // Reference decode straight from the instruction-set rules.
    function automatic dec_t model_dec(input logic [31:0] i);
        dec_t        d;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        imm_i = 32'($signed(i[31:20]));
        imm_s = 32'($signed({i[31:25], i[11:7]}));
        imm_b = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        imm_u = {i[31:12], 12'h000};
        imm_j = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        d = '0;
        d.ill = (i[1:0] != 2'b11);
        case (op)
            7'h33: begin
                d.alu = {i[30] && (f3 == 3'd0 || f3 == 3'd5), f3};
                if (f7 == 7'h20) begin
                    if (!(f3 == 3'd0 || f3 == 3'd5)) d.ill = 1'b1;
                end else if (f7 != 7'h00) d.ill = 1'b1;
            end
            7'h13: begin
                d.alu = {f3 == 3'd5 && i[30], f3};
                d.b = 1'b1; d.imm = imm_i;
                if (f3 == 3'd1 && f7 != 7'h00) d.ill = 1'b1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) d.ill = 1'b1;
            end
            7'h37: begin d.alu = 4'hE; d.b = 1'b1; d.imm = imm_u; end
            7'h17: begin d.a = 1'b1; d.b = 1'b1; d.imm = imm_u; end
            7'h6F: begin d.a = 1'b1; d.b = 1'b1; d.imm = imm_j; end
            7'h63: begin d.a = 1'b1; d.b = 1'b1; d.imm = imm_b; end
            7'h67, 7'h03: begin d.b = 1'b1; d.imm = imm_i; end
            7'h23: begin d.b = 1'b1; d.imm = imm_s; end
            7'h73: begin
                if (f3[2]) begin
                    d.alu = 4'hE; d.b = 1'b1; d.imm = {27'd0, i[19:15]};
                end else d.alu = 4'hF;
            end
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    // Transaction-level register model.
    logic         m_known = 1'b0;
    logic         m_valid;
    logic         m_rst;
    dec_t         m_dec;
    logic [W-1:0] m_pc;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known <= 1'b1;
            m_valid <= 1'b0;
            m_rst   <= 1'b1;
            m_dec   <= '0;
            m_pc    <= '0;
        end else if (m_known) begin
            if (flush) m_valid <= 1'b0;
            else if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_rst   <= 1'b0;
                m_dec   <= model_dec(inst);
                m_pc    <= pc_in;
            end else if (out_ready) m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("out_valid", out_valid, m_valid);
            chk("in_ready", in_ready, !m_valid || out_ready);
            if (m_valid || m_rst) begin
                chk("alu_sel", alu_sel, m_dec.alu);
                chk("a_sel", a_sel, m_dec.a);
                chk("b_sel", b_sel, m_dec.b);
                chk("imm", imm, m_dec.imm);
                chk("pc_out", pc_out, m_pc);
`ifdef ALU_DEC_ILLEGAL_EN
                chk("illegal", illegal, m_dec.ill);
`endif
            end
        end
    end

    logic [31:0] vec [12] = '{
        32'h402081B3, 32'h0020A1B3, 32'h008000EF, 32'h00408067,
        32'hFFC12083, 32'hFE112E23, 32'h30029073, 32'h3002D073,
        32'h0000000F, 32'h00004501, 32'h02009093, 32'h4020F1B3
    };

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        inst = '0; pc_in = '0;
        cyc(); cyc();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_alu", alu_sel, 4'h0);
        chk("rst_ab", {a_sel, b_sel}, 2'b00);
        chk("rst_imm", imm, 32'h0);
        chk("rst_pc", pc_out, 32'h0);

        rst_n = 1'b1; in_valid = 1'b1;
        inst = 32'h002081B3; pc_in = 32'h0;
        cyc();
        chk("add_valid", out_valid, 1'b1);
        chk("add_alu", alu_sel, 4'b0000);
        chk("add_ab", {a_sel, b_sel}, 2'b00);

        inst = 32'h40335293; pc_in = 32'h4;
        cyc();
        chk("srai_alu", alu_sel, 4'b1101);
        chk("srai_b", b_sel, 1'b1);
        chk("srai_imm", imm, 32'h00000403);

        inst = 32'h123450B7; pc_in = 32'h8;
        cyc();
        chk("lui_alu", alu_sel, 4'b1110);
        chk("lui_imm", imm, 32'h12345000);

        inst = 32'hFE000EE3; pc_in = 32'h100;
        cyc();
        chk("beq_alu", alu_sel, 4'b0000);
        chk("beq_ab", {a_sel, b_sel}, 2'b11);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_pc", pc_out, 32'h100);

        // Stall with a pending AUIPC x1,1 on the input.
        out_ready = 1'b0; inst = 32'h00001097; pc_in = 32'h104;
        #1;
        chk("stall_in_ready0", in_ready, 1'b0);
        repeat (3) begin
            cyc();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_pc", pc_out, 32'h100);
            chk("stall_imm", imm, 32'hFFFFFFFC);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        flush = 1'b1;
        cyc();
        chk("flush_valid", out_valid, 1'b0);
        cyc();
        chk("flush_drop_valid", out_valid, 1'b0);
        flush = 1'b0; out_ready = 1'b1;
        cyc();
        chk("auipc_valid", out_valid, 1'b1);
        chk("auipc_ab", {a_sel, b_sel}, 2'b11);
        chk("auipc_imm", imm, 32'h00001000);
        chk("auipc_pc", pc_out, 32'h104);

        inst = 32'h0000007F;
        cyc();
        chk("unk_alu", alu_sel, 4'b0000);
        chk("unk_ab", {a_sel, b_sel}, 2'b00);
`ifdef ALU_DEC_ILLEGAL_EN
        chk("unk_illegal", illegal, 1'b1);
`endif
        inst = 32'h4020F1B3;
        cyc();
        chk("rand_alu", alu_sel, 4'b0111);
`ifdef ALU_DEC_ILLEGAL_EN
        chk("rand_illegal", illegal, 1'b1);
`endif
        inst = 32'h3002D073;
        cyc();
        chk("csrrwi_alu", alu_sel, 4'b1110);
        chk("csrrwi_imm", imm, 32'h5);

        for (int k = 0; k < 12; k++) begin
            inst = vec[k]; pc_in = 32'h200 + 32'(k * 4);
            cyc();
        end

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            inst      = $urandom_range(0, 1) ? vec[$urandom_range(0, 11)] : $urandom;
            pc_in     = $urandom;
            cyc();
        end

        // Reset while stalled discards the held entry.
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        inst = 32'h123450B7; pc_in = 32'h300;
        cyc();
        out_ready = 1'b0;
        cyc();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_alu", alu_sel, 4'h0);
        chk("midrst_imm", imm, 32'h0);
        chk("midrst_pc", pc_out, 32'h0);
`ifdef ALU_DEC_ILLEGAL_EN
        chk("midrst_illegal", illegal, 1'b0);
`endif
        rst_n = 1'b1; in_valid = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
